result_argmax_unit: RTL and testbench
=====================================

// Module: result_argmax_unit
// PURPOSE
//  Downstream of the dot-product Controller/accumulator datapath. Captures the NQ signed
//  accumulator results of one frame (one per res_write pulse) and tracks the running
//  argmax. After the controller's done pulse, exposes the buffered results to a consumer
//  over a valid/enable handshake and publishes max_idx/max_val.
// PARAMETERS
//  ACC_W  16  width of one signed two's-complement accumulator result
//  NQ     4   results per frame (matches controller Q count); buffer depth
//  IDX_W  2   index width, must satisfy 2**IDX_W >= NQ
// PORTS
//  clk           in   1      clock, all state updates on posedge
//  rst           in   1      asynchronous, active-high reset
//  st            in   1      start a new frame; sampled in IDLE and DONE only
//  res_write     in   1      one-cycle result strobe from controller
//  res_data      in   ACC_W  signed result, valid when res_write=1
//  ctrl_done     in   1      controller done pulse (frame complete)
//  rd_en         in   1      consumer pop; effective only when rd_valid=1
//  rd_data       out  ACC_W  buffered result at read pointer (comb. from buffer)
//  rd_valid      out  1      rd_data holds an unread result
//  max_idx       out  IDX_W  index of largest result (earliest on tie)
//  max_val       out  ACC_W  value of largest result
//  result_ready  out  1      max_idx/max_val final for current frame
//  overflow      out  1      sticky: more than NQ results arrived this frame
// BEHAVIOUR
//  - Reset: state=IDLE, wr_cnt=0, rd_ptr=0; rd_valid, result_ready, overflow,
//    max_idx, max_val all 0; rd_data reads 0. Reset mid-frame discards everything.
//  - FSM: IDLE -st-> COLLECT; COLLECT -ctrl_done-> DRAIN (wr_cnt>0) or DONE (wr_cnt=0);
//    DRAIN -last pop-> DONE; DONE -st-> COLLECT. st ignored in COLLECT/DRAIN.
//  - Entering COLLECT from IDLE/DONE clears wr_cnt, rd_ptr, max_idx, max_val,
//    overflow, result_ready.
//  - COLLECT, res_write=1: if wr_cnt<NQ: buf[wr_cnt]<=v, wr_cnt++; if wr_cnt==0 or
//    v>max_val (signed, strict) then max_val<=v, max_idx<=wr_cnt. If wr_cnt==NQ: drop, overflow<=1.
//  - res_write and ctrl_done in same cycle: result captured first, then transition;
//    the count used for the DRAIN/DONE choice includes that result.
//  - Latency: stored value and max update visible 1 cycle after the res_write edge;
//    result_ready rises 1 cycle after ctrl_done, stays high in DRAIN and DONE.
//  - DRAIN: rd_valid=(rd_ptr<wr_cnt); rd_en&rd_valid -> rd_ptr++ next edge; rd_en low
//    stalls with rd_data stable; pop with rd_ptr==wr_cnt-1 -> DONE. rd_valid=0 elsewhere.
//  - Zero-result frame: max_idx=0, max_val=0, result_ready=1, rd_valid never asserts.
//  - rd_ptr/wr_cnt never wrap; both are IDX_W+1 bits to represent NQ.
// CONFIGURATION
//  RESULT_RELU_EN defined: v = (res_data<0) ? 0 : res_data, applied before store and compare.
//  RESULT_RELU_EN undefined: v = res_data unmodified (negatives stored and compared signed).
// STRUCTURE
//  Shared package cad_pkg: FSM state encoding (IDLE/COLLECT/DRAIN/DONE, 2 bits) and
//  default ACC_W/NQ/IDX_W constants shared with the Controller/datapath.
//  One sub-module: max_tracker (holds max_val/max_idx, signed strict-greater compare,
//  clear/load controls). Buffer, pointers and FSM live in the top.
// TESTING (ACC_W=16, NQ=4, IDX_W=2)
//  1. st; results 5,-3,9,9; ctrl_done -> max_idx=2, max_val=9, result_ready=1; rd_en held
//     -> rd_data 5,-3,9,9 on 4 cycles, then DONE, rd_valid=0.
//  2. results -7,-2,-9,-4 -> no macro: max_idx=1, max_val=-2; RESULT_RELU_EN: stored
//     0,0,0,0, max_idx=0, max_val=0.
//  3. five res_write pulses 1,2,3,4,50 -> overflow=1, max_val=4, max_idx=3, 4 results drained.
//  4. ctrl_done with no results -> DONE next cycle, result_ready=1, max_val=0, rd_valid stays 0.
//  5. 4th result and ctrl_done same cycle; rd_en toggled 1,0,0,1 -> all 4 drained,
//     rd_data constant while rd_en=0.
//  6. rst pulse after 2 results -> all outputs 0, IDLE; new st + frame behaves as test 1.

Source files
------------

// File: rtl/cad_pkg.sv
// Shared definitions for the dot-product controller, datapath and result argmax unit:
// FSM state encoding of the result unit and default frame geometry.
package cad_pkg;

  // Result unit FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Default geometry shared with the controller/accumulator datapath.
  localparam int CAD_ACC_W = 16;
  localparam int CAD_NQ    = 4;
  localparam int CAD_IDX_W = 2;

endpackage : cad_pkg

// File: rtl/result_argmax_unit_max_tracker.sv
// max_tracker: holds the running maximum value and its index for one frame.
// A candidate replaces the stored maximum when it is the first of the frame or
// strictly greater (signed) than the current maximum, so ties keep the earliest index.
module max_tracker #(
  parameter int ACC_W = 16,
  parameter int IDX_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic                    first_i,
  input  logic signed [ACC_W-1:0] cand_val_i,
  input  logic        [IDX_W-1:0] cand_idx_i,
  output logic signed [ACC_W-1:0] max_val_o,
  output logic        [IDX_W-1:0] max_idx_o
);

  logic signed [ACC_W-1:0] max_val_q, max_val_d;
  logic        [IDX_W-1:0] max_idx_q, max_idx_d;

  // Next-state: clear on frame start, otherwise take a qualifying candidate.
  always_comb begin
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    if (clr_i) begin
      max_val_d = '0;
      max_idx_d = '0;
    end else if (load_i && (first_i || (cand_val_i > max_val_q))) begin
      max_val_d = cand_val_i;
      max_idx_d = cand_idx_i;
    end
  end

  // Maximum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign max_val_o = max_val_q;
  assign max_idx_o = max_idx_q;

endmodule : max_tracker

// File: rtl/result_argmax_unit.sv
// result_argmax_unit: buffers the NQ accumulator results of one frame, tracks the
// argmax, and after the controller's done pulse drains the buffer to a consumer.
// Optional macro RESULT_RELU_EN: clamp negative results to zero before store and compare.
//
// Read handshake: rd_valid is high in DRAIN while an unread result sits at the read
// pointer; a cycle with rd_valid=1 and rd_en=1 transfers rd_data and advances the
// pointer on the next edge. rd_en without rd_valid has no effect, and rd_data holds
// stable while rd_en is low.
import cad_pkg::*;

module result_argmax_unit #(
  parameter int ACC_W = CAD_ACC_W,
  parameter int NQ    = CAD_NQ,
  parameter int IDX_W = CAD_IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st,
  input  logic                    res_write,
  input  logic signed [ACC_W-1:0] res_data,
  input  logic                    ctrl_done,
  input  logic                    rd_en,
  output logic signed [ACC_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic        [IDX_W-1:0] max_idx,
  output logic signed [ACC_W-1:0] max_val,
  output logic                    result_ready,
  output logic                    overflow,
  output state_t                  dbg_state
);

  localparam logic [IDX_W:0] NQ_C = (IDX_W+1)'(NQ);

  state_t                  state_q;
  logic [IDX_W:0]          wr_cnt_q;
  logic [IDX_W:0]          rd_ptr_q;
  logic signed [ACC_W-1:0] buf_q [NQ];
  logic                    overflow_q;
  logic                    result_ready_q;

  logic signed [ACC_W-1:0] v;
  logic                    start;
  logic                    accept;
  logic [IDX_W:0]          cnt_after;
  logic                    pop;

  // Value actually stored and compared for the incoming result.
  always_comb begin
`ifdef RESULT_RELU_EN
    v = res_data[ACC_W-1] ? '0 : res_data;
`else
    v = res_data;
`endif
  end

  // Control decodes shared by the FSM, buffer and tracker.
  always_comb begin
    start     = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && st;
    accept    = (state_q == ST_COLLECT) && res_write && (wr_cnt_q < NQ_C);
    cnt_after = wr_cnt_q + {{IDX_W{1'b0}}, accept};
    rd_valid  = (state_q == ST_DRAIN) && (rd_ptr_q < wr_cnt_q);
    pop       = rd_valid && rd_en;
    rd_data   = (rd_ptr_q < NQ_C) ? buf_q[rd_ptr_q[IDX_W-1:0]] : '0;
  end

  // Result buffer; reset to zero so rd_data reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NQ; i++) buf_q[i] <= '0;
    end else if (accept) begin
      buf_q[wr_cnt_q[IDX_W-1:0]] <= v;
    end
  end

  // Frame FSM with write/read pointers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wr_cnt_q       <= '0;
      rd_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      result_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q        <= ST_COLLECT;
            wr_cnt_q       <= '0;
            rd_ptr_q       <= '0;
            overflow_q     <= 1'b0;
            result_ready_q <= 1'b0;
          end
        end
        ST_COLLECT: begin
          wr_cnt_q <= cnt_after;
          if (res_write && !accept) overflow_q <= 1'b1;
          // The count including a same-cycle result decides DRAIN vs DONE.
          if (ctrl_done) begin
            result_ready_q <= 1'b1;
            state_q        <= (cnt_after != '0) ? ST_DRAIN : ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_ptr_q == wr_cnt_q - 1'b1) state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  max_tracker #(
    .ACC_W (ACC_W),
    .IDX_W (IDX_W)
  ) u_max_tracker (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start),
    .load_i     (accept),
    .first_i    (wr_cnt_q == '0),
    .cand_val_i (v),
    .cand_idx_i (wr_cnt_q[IDX_W-1:0]),
    .max_val_o  (max_val),
    .max_idx_o  (max_idx)
  );

  assign result_ready = result_ready_q;
  assign overflow     = overflow_q;
  assign dbg_state    = state_q;

endmodule : result_argmax_unit

// File: tb/tb_result_argmax_unit.sv
// Directed bench for result_argmax_unit (ACC_W=16, NQ=4, IDX_W=2).
// Handles both builds: with RESULT_RELU_EN defined, expectations clamp negatives to 0.
import cad_pkg::*;

module tb_result_argmax_unit;

  localparam int ACC_W = 16;
  localparam int NQ    = 4;
  localparam int IDX_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                    st, res_write, ctrl_done, rd_en;
  logic signed [ACC_W-1:0] res_data;
  logic signed [ACC_W-1:0] rd_data;
  logic                    rd_valid;
  logic        [IDX_W-1:0] max_idx;
  logic signed [ACC_W-1:0] max_val;
  logic                    result_ready, overflow;
  state_t                  dbg_state;

  result_argmax_unit #(.ACC_W(ACC_W), .NQ(NQ), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .st           (st),
    .res_write    (res_write),
    .res_data     (res_data),
    .ctrl_done    (ctrl_done),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .max_idx      (max_idx),
    .max_val      (max_val),
    .result_ready (result_ready),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [ACC_W-1:0] exp_q[$];
  int model_cnt = 0;

  task automatic check(input string tag, input logic [ACC_W-1:0] got,
                       input logic [ACC_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
`ifdef RESULT_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    st = 1'b1;
    tick();
    st = 1'b0;
    exp_q.delete();
    model_cnt = 0;
  endtask

  task automatic push_model(input logic signed [ACC_W-1:0] x);
    if (model_cnt < NQ) begin
      exp_q.push_back(relu(x));
      model_cnt++;
    end
  endtask

  task automatic write_res(input logic signed [ACC_W-1:0] x, input logic with_done);
    res_write = 1'b1;
    res_data  = x;
    ctrl_done = with_done;
    push_model(x);
    tick();
    res_write = 1'b0;
    ctrl_done = 1'b0;
    res_data  = '0;
  endtask

  task automatic done_pulse();
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
  endtask

  // Drain with rd_en held high; each cycle must present the next expected result.
  task automatic drain_all(input string tag);
    int n;
    n = exp_q.size();
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_rd_valid"}, {15'd0, rd_valid}, 16'd1);
      check({tag, "_rd_data"}, rd_data, exp_q.pop_front());
      tick();
    end
    rd_en = 1'b0;
    check({tag, "_end_rd_valid"}, {15'd0, rd_valid}, 16'd0);
    check({tag, "_end_state"}, {14'd0, dbg_state}, {14'd0, ST_DONE});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {14'd0, dbg_state}, {14'd0, ST_IDLE});
    check({tag, "_rd_valid"}, {15'd0, rd_valid}, 16'd0);
    check({tag, "_rd_data"}, rd_data, 16'd0);
    check({tag, "_max_idx"}, {14'd0, max_idx}, 16'd0);
    check({tag, "_max_val"}, max_val, 16'd0);
    check({tag, "_result_ready"}, {15'd0, result_ready}, 16'd0);
    check({tag, "_overflow"}, {15'd0, overflow}, 16'd0);
  endtask

  // Frame 5,-3,9,9: max at index 2 (earliest of the tie), value 9 in both builds.
  task automatic basic_frame(input string tag);
    start_frame();
    check({tag, "_state_collect"}, {14'd0, dbg_state}, {14'd0, ST_COLLECT});
    write_res(16'sd5, 1'b0);
    check({tag, "_max_after1"}, max_val, 16'd5);
    write_res(-16'sd3, 1'b0);
    write_res(16'sd9, 1'b0);
    write_res(16'sd9, 1'b0);
    check({tag, "_ready_before_done"}, {15'd0, result_ready}, 16'd0);
    done_pulse();
    check({tag, "_state_drain"}, {14'd0, dbg_state}, {14'd0, ST_DRAIN});
    check({tag, "_result_ready"}, {15'd0, result_ready}, 16'd1);
    check({tag, "_max_idx"}, {14'd0, max_idx}, 16'd2);
    check({tag, "_max_val"}, max_val, 16'd9);
    drain_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ACC_W-1:0] exp_v;
    logic [IDX_W-1:0] exp_i;
    logic             pat [4];
    rst = 1'b1; st = 1'b0; res_write = 1'b0; res_data = '0; ctrl_done = 1'b0; rd_en = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");

    // st must be ignored while collecting or draining is covered implicitly below.
    // Test 1
    basic_frame("t1");

    // Test 2: all-negative frame
    start_frame();
    write_res(-16'sd7, 1'b0);
    write_res(-16'sd2, 1'b0);
    write_res(-16'sd9, 1'b0);
    write_res(-16'sd4, 1'b0);
    done_pulse();
`ifdef RESULT_RELU_EN
    exp_v = 16'd0;
    exp_i = 2'd0;
`else
    exp_v = 16'hFFFE;
    exp_i = 2'd1;
`endif
    check("t2_max_idx", {14'd0, max_idx}, {14'd0, exp_i});
    check("t2_max_val", max_val, exp_v);
    drain_all("t2");

    // Test 3: five results, fifth dropped
    start_frame();
    check("t3_overflow_cleared", {15'd0, overflow}, 16'd0);
    write_res(16'sd1, 1'b0);
    write_res(16'sd2, 1'b0);
    write_res(16'sd3, 1'b0);
    write_res(16'sd4, 1'b0);
    check("t3_overflow_before", {15'd0, overflow}, 16'd0);
    write_res(16'sd50, 1'b0);
    check("t3_overflow", {15'd0, overflow}, 16'd1);
    check("t3_max_val", max_val, 16'd4);
    check("t3_max_idx", {14'd0, max_idx}, 16'd3);
    done_pulse();
    check("t3_overflow_sticky", {15'd0, overflow}, 16'd1);
    drain_all("t3");

    // Test 4: empty frame
    start_frame();
    check("t4_ready_cleared", {15'd0, result_ready}, 16'd0);
    done_pulse();
    check("t4_state", {14'd0, dbg_state}, {14'd0, ST_DONE});
    check("t4_result_ready", {15'd0, result_ready}, 16'd1);
    check("t4_max_val", max_val, 16'd0);
    check("t4_max_idx", {14'd0, max_idx}, 16'd0);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_rd_valid", {15'd0, rd_valid}, 16'd0);
      tick();
    end
    rd_en = 1'b0;

    // Test 5: last result with ctrl_done, stalling consumer
    start_frame();
    write_res(16'sd7, 1'b0);
    write_res(-16'sd1, 1'b0);
    write_res(16'sd3, 1'b0);
    st = 1'b1;  // ignored in COLLECT
    write_res(16'sd8, 1'b1);
    st = 1'b0;
    check("t5_state_drain", {14'd0, dbg_state}, {14'd0, ST_DRAIN});
    check("t5_max_idx", {14'd0, max_idx}, 16'd3);
    check("t5_max_val", max_val, 16'd8);
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      rd_en = pat[cyc % 4];
      check("t5_rd_valid", {15'd0, rd_valid}, 16'd1);
      check("t5_rd_data", rd_data, exp_q[0]);
      if (rd_en) void'(exp_q.pop_front());
      tick();
    end
    rd_en = 1'b0;
    check("t5_left_in_queue", 16'(exp_q.size()), 16'd0);
    check("t5_state_done", {14'd0, dbg_state}, {14'd0, ST_DONE});

    // Test 6: reset mid-frame, then a normal frame
    start_frame();
    write_res(16'sd11, 1'b0);
    write_res(16'sd12, 1'b0);
    rst = 1'b1;
    #2;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_reset_outputs("t6_after");
    basic_frame("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_result_argmax_unit
